// File: rtl/scsi_arb_pkg.sv
// Shared state encoding, DMA direction codes and default limits for the
// SCSI access arbiter.
package scsi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CPU_GNT  = 3'd1,
    ST_CPU_DONE = 3'd2,
    ST_CPU_TMO  = 3'd3,
    ST_DMA_GNT  = 3'd4,
    ST_DMA_BYTE = 3'd5,
    ST_RECOVER  = 3'd6
  } arb_state_t;

  localparam logic DMADIR_S2F = 1'b1;
  localparam logic DMADIR_F2S = 1'b0;

  localparam int DEF_DMA_BURST_MAX = 4;
  localparam int DEF_TIMEOUT_CYC   = 255;

endpackage

// File: rtl/arb_tmo_ctr.sv
// Purpose: 8-bit saturating watchdog counter with terminal count at TIMEOUT_CYC-1.
// Latency: clear/increment take effect at the next edge; tc is a decode of the count.
// Backpressure: none; free-running while enabled, holds at 8'hFF.
module arb_tmo_ctr #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic CPUCLK,
  input  logic RESET,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [7:0] TC_VAL = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt;

  always_ff @(posedge CPUCLK) begin
    if (RESET || clr) begin
      cnt <= '0;
    end else if (en && (cnt != 8'hFF)) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/scsi_access_arb.sv
// Purpose: arbitrates the SCSI controller access path between CPU register and DMA byte cycles.
// Latency: a request sampled in IDLE is granted the cycle after that edge; DREQ_Q follows DREQ_ combinationally while DMA is granted.
// Backpressure: a waiting CPU yields to at most DMA_BURST_MAX bytes; RECOVER holds until the CPU releases its request.
module scsi_access_arb
  import scsi_arb_pkg::*;
#(
  parameter int DMA_BURST_MAX = DEF_DMA_BURST_MAX,
  parameter int TIMEOUT_CYC   = DEF_TIMEOUT_CYC
) (
  input  logic       CPUCLK,
  input  logic       RESET,
  input  logic       CPU_REQ,
  input  logic       DMAENA,
  input  logic       DMADIR,
  input  logic       DREQ_,
  input  logic       FIFOFULL,
  input  logic       FIFOEMPTY,
  input  logic       LS2CPU,
  input  logic       DACK,
  output logic       CPUREQ,
  output logic       DREQ_Q,
  output logic       CPU_ACK,
  output logic       CPU_BERR,
  output logic       DMA_ERR,
  output logic [2:0] ARB_STATE
);

  localparam logic [3:0] BURST_MAX = 4'(DMA_BURST_MAX);

  arb_state_t state, state_nxt;
  logic [3:0] burst_cnt, burst_nxt;
  logic       dma_err, dma_err_nxt;
  logic       dma_elig;
  logic       tmo_tc;
  logic       tmo_en;

  assign dma_elig = DMAENA & ~DREQ_ & ~dma_err &
                    ((DMADIR == DMADIR_S2F) ? ~FIFOFULL : ~FIFOEMPTY);

  always_comb begin
    state_nxt   = state;
    burst_nxt   = burst_cnt;
    dma_err_nxt = dma_err;
    unique case (state)
      ST_IDLE: begin
        if (!DMAENA) dma_err_nxt = 1'b0;
        // DMA wins ties until the burst allowance for a waiting CPU is used up
        if (CPU_REQ && (!dma_elig || (burst_cnt == BURST_MAX))) state_nxt = ST_CPU_GNT;
        else if (dma_elig)                                       state_nxt = ST_DMA_GNT;
      end
      ST_CPU_GNT: begin
        if (LS2CPU)      state_nxt = ST_CPU_DONE;
        else if (tmo_tc) state_nxt = ST_CPU_TMO;
      end
      ST_CPU_DONE, ST_CPU_TMO: begin
        burst_nxt = '0;
        state_nxt = ST_RECOVER;
      end
      ST_RECOVER: begin
        if (!LS2CPU && !CPU_REQ) state_nxt = ST_IDLE;
      end
      ST_DMA_GNT: begin
        if (DACK) begin
          state_nxt = ST_DMA_BYTE;
        end else if (DREQ_ || !DMAENA) begin
          state_nxt = ST_IDLE;
        end else if (tmo_tc) begin
          state_nxt   = ST_IDLE;
          dma_err_nxt = 1'b1;
        end
      end
      ST_DMA_BYTE: begin
        if (!DACK) begin
          state_nxt = ST_IDLE;
          if (!CPU_REQ)                    burst_nxt = '0;
          else if (burst_cnt < BURST_MAX)  burst_nxt = burst_cnt + 4'd1;
        end else if (tmo_tc) begin
          state_nxt   = ST_IDLE;
          dma_err_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CPUCLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      burst_cnt <= '0;
      dma_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      dma_err   <= dma_err_nxt;
    end
  end

  assign tmo_en = (state == ST_CPU_GNT) || (state == ST_DMA_GNT) || (state == ST_DMA_BYTE);

  arb_tmo_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .CPUCLK (CPUCLK),
    .RESET  (RESET),
    .clr    (state_nxt != state),
    .en     (tmo_en),
    .tc     (tmo_tc)
  );

  assign CPUREQ    = (state == ST_CPU_GNT);
  assign DREQ_Q    = ((state == ST_DMA_GNT) || (state == ST_DMA_BYTE)) ? DREQ_ : 1'b1;
  assign CPU_ACK   = (state == ST_CPU_DONE);
  assign CPU_BERR  = (state == ST_CPU_TMO);
  assign DMA_ERR   = dma_err;
  assign ARB_STATE = state;

endmodule
